// File: rtl/ks_add_arbiter.sv
// ---------------------------------------------------------------------------
// ks_add_arbiter
// Shares one pipelined W-bit adder between NREQ requesters. A round-robin
// arbiter grants at most one requester per cycle, the accepted operation is
// registered onto the adder issue port, and a tag pipeline follows it through
// the adder so the result is returned with the requester id LAT+2 cycles
// after the accept.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_en                global grant enable (in-flight work always completes)
//   i_req_valid         per-requester operation valid
//   o_req_ready         per-requester grant (one-hot or zero, combinational)
//   i_req_a, i_req_b    packed operands, slice k belongs to requester k
//   i_req_sub           per-requester op select: 1 = A-B, 0 = A+B
//   o_add_*             registered issue port to the adder
//   i_add_sum/cout      adder result, valid LAT cycles after issue
//   o_rsp_*             registered one-cycle result pulse with requester id
//   o_idle              nothing issued, in the tag pipeline or responding
// ---------------------------------------------------------------------------
module ks_add_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int LAT  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [NREQ*W-1:0]        i_req_a,
    input  logic [NREQ*W-1:0]        i_req_b,
    input  logic [NREQ-1:0]          i_req_sub,
    output logic                     o_add_valid,
    output logic [W-1:0]             o_add_a,
    output logic [W-1:0]             o_add_b,
    output logic                     o_add_cin,
    input  logic [W-1:0]             i_add_sum,
    input  logic                     i_add_cout,
    output logic                     o_rsp_valid,
    output logic [$clog2(NREQ)-1:0]  o_rsp_id,
    output logic [W-1:0]             o_rsp_sum,
    output logic                     o_rsp_cout,
    output logic                     o_idle
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

    // Arbiter state and combinational grant
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic            grant_en_s;
    logic            accept_s;
    logic            hit_s;
    logic [IDW:0]    cand_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [NREQ-1:0] gnt_s;

    // Granted operands, selected from the packed request buses
    logic [W-1:0]    sel_a_s;
    logic [W-1:0]    sel_b_s;
    logic            sel_sub_s;

    // Issue register and tag pipeline. Stage 0 is the issue cycle itself
    // (it is o_add_valid); stage LAT is the cycle the adder result is valid.
    logic [W-1:0]    add_a_q;
    logic [W-1:0]    add_b_q;
    logic            add_cin_q;
    logic [LAT:0]    tag_vld_q;
    logic [IDW-1:0]  tag_id_q [0:LAT];

    // Response register
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    rsp_sum_q;
    logic            rsp_cout_q;

    // Round-robin search: first valid requester at or after the pointer,
    // wrapping past NREQ-1 back to 0. Grants are blocked in reset.
    always_comb begin
        grant_en_s = i_en & i_rst_n;
        accept_s   = 1'b0;
        hit_s      = 1'b0;
        cand_s     = '0;
        gnt_idx_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s    = {1'b0, ptr_q} + (IDW+1)'(i);
            cand_s    = (cand_s >= (IDW+1)'(NREQ)) ? (cand_s - (IDW+1)'(NREQ)) : cand_s;
            hit_s     = grant_en_s & ~accept_s & i_req_valid[cand_s[IDW-1:0]];
            gnt_idx_s = hit_s ? cand_s[IDW-1:0] : gnt_idx_s;
            accept_s  = accept_s | hit_s;
        end
        gnt_s = accept_s ? (ONE_HOT << gnt_idx_s) : {NREQ{1'b0}};
        ptr_d = accept_s ? ((gnt_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (gnt_idx_s + 1'b1))
                         : ptr_q;
    end

    // Operand mux for the granted requester; subtraction is A + ~B + 1
    always_comb begin
        sel_a_s   = i_req_a[gnt_idx_s*W +: W];
        sel_b_s   = i_req_sub[gnt_idx_s] ? ~i_req_b[gnt_idx_s*W +: W] : i_req_b[gnt_idx_s*W +: W];
        sel_sub_s = i_req_sub[gnt_idx_s];
    end

    // Pointer, issue register, tag pipeline and response capture
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            tag_vld_q   <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id_q[k] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= accept_s;
            // Operands hold between issues so the adder inputs do not toggle
            if (accept_s) begin
                add_a_q     <= sel_a_s;
                add_b_q     <= sel_b_s;
                add_cin_q   <= sel_sub_s;
                tag_id_q[0] <= gnt_idx_s;
            end
            for (int k = 1; k <= LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
            // The adder result lines up with the last tag stage
            rsp_valid_q <= tag_vld_q[LAT];
            if (tag_vld_q[LAT]) begin
                rsp_id_q   <= tag_id_q[LAT];
                rsp_sum_q  <= i_add_sum;
                rsp_cout_q <= i_add_cout;
            end
        end
    end

    assign o_req_ready = gnt_s;
    assign o_add_valid = tag_vld_q[0];
    assign o_add_a     = add_a_q;
    assign o_add_b     = add_b_q;
    assign o_add_cin   = add_cin_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_sum   = rsp_sum_q;
    assign o_rsp_cout  = rsp_cout_q;
    assign o_idle      = ~(|tag_vld_q) & ~rsp_valid_q;

endmodule

// File: doc/ks_add_arbiter.md
KS_ADD_ARBITER -- requirements
Module: ks_add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one Kogge-Stone adder (2..8).
REQ-002 Parameter W, default 16: operand width; matches the 16-bit Kogge-Stone adder.
REQ-003 Parameter LAT, default 2: adder pipeline latency in cycles from o_add_* to i_add_* (0..7).
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst_n  in  1  synchronous active-low reset.
REQ-007 i_en  in  1  global grant enable.
REQ-008 i_req_valid  in  NREQ  per-requester operation valid.
REQ-009 o_req_ready  out  NREQ  per-requester grant; accept = valid & ready.
REQ-010 i_req_a  in  NREQ*W  operand A; slice k belongs to requester k.
REQ-011 i_req_b  in  NREQ*W  operand B; slice k belongs to requester k.
REQ-012 i_req_sub  in  NREQ  1 = A-B, 0 = A+B.
REQ-013 o_add_valid, o_add_a[W], o_add_b[W], o_add_cin  out  issue port to the adder.
REQ-014 i_add_sum  in  W; i_add_cout  in  1  adder result, valid LAT cycles after issue.
REQ-015 o_rsp_valid  out  1; o_rsp_id  out  clog2(NREQ); o_rsp_sum  out  W; o_rsp_cout  out  1  result return.
REQ-016 o_idle  out  1  no transaction in flight.

Function
REQ-017 At most one requester SHALL be granted per cycle; o_req_ready is one-hot or zero.
REQ-018 Grant SHALL be round-robin: the lowest index >= pointer with valid high, wrapping to 0; pointer becomes granted index + 1 mod NREQ after each accept.
REQ-019 o_req_ready SHALL be combinational from i_req_valid, the pointer and i_en; with i_en=0, o_req_ready SHALL be all zero.
REQ-020 A requester with valid low SHALL never be granted; the pointer SHALL hold when no accept occurs.
REQ-021 An accept in cycle T SHALL register o_add_valid=1 and the operands in cycle T+1.
REQ-022 For add: o_add_a=A, o_add_b=B, o_add_cin=0. For sub: o_add_a=A, o_add_b=~B, o_add_cin=1.
REQ-023 In cycles with no accept, o_add_valid SHALL be 0 and o_add_a/b/cin SHALL hold their previous values.
REQ-024 A tag pipeline of LAT stages (valid + id) SHALL track each issue; i_add_sum/i_add_cout SHALL be sampled when the tag reaches stage LAT (cycle T+1+LAT).
REQ-025 o_rsp_valid SHALL pulse for exactly one cycle at T+2+LAT, carrying the granted id, sum and cout. Responses have no backpressure.
REQ-026 Sustained throughput SHALL be one operation per cycle; responses SHALL return in grant order.
REQ-027 o_rsp_sum/o_rsp_id/o_rsp_cout SHALL hold their last values while o_rsp_valid=0.
REQ-028 Arithmetic SHALL be modulo 2^W; the carry out is reported raw: for sub, cout=1 means no borrow.
REQ-029 Deasserting i_en SHALL NOT cancel in-flight operations; all issued operations SHALL complete.
REQ-030 o_idle SHALL be 1 exactly when o_add_valid, every tag-stage valid and o_rsp_valid are all 0.

Reset
REQ-031 While i_rst_n=0 at a clock edge, the block SHALL:
- clear the pointer to 0 and all tag valids;
- drive o_add_valid=0, o_add_a/b=0, o_add_cin=0;
- drive o_rsp_valid=0, o_rsp_id=0, o_rsp_sum=0, o_rsp_cout=0;
- drive o_idle=1.
REQ-032 Reset mid-operation SHALL discard in-flight operations; no o_rsp_valid pulse SHALL be produced for them after reset releases.
REQ-033 o_req_ready SHALL be 0 while i_rst_n=0.

Verification (NREQ=4, W=16, LAT=2, ideal adder model)
REQ-034 Req0 A=0x1234, B=0x0FFF, add, accepted at T -> o_add at T+1 (0x1234, 0x0FFF, cin 0); o_rsp at T+4 with id 0, sum 0x2233, cout 0.
REQ-035 Req2 A=0x0005, B=0x0007, sub -> o_add_b=0xFFF8, cin 1; rsp id 2, sum 0xFFFE, cout 0.
REQ-036 Req1 A=0xFFFF, B=0x0001, add -> rsp sum 0x0000, cout 1.
REQ-037 All four valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles; rsp ids in the same order, back-to-back; o_idle=0 throughout.
REQ-038 Two accepts, then i_en=0 -> no further ready; both rsp delivered at T+4 and T+5; o_idle=1 from T+6.
REQ-039 Accept at T, then i_rst_n=0 at T+1 for one cycle -> no o_rsp_valid pulse; all outputs 0; the first grant after release goes to req0 when all requesters are valid.
